lbm_axis_pixel_unpacker: RTL and testbench
==========================================

Name: lbm_axis_pixel_unpacker

Overview:
Parametrised AXI-Stream slave that accepts one packed lattice-Boltzmann pixel per beat (NUM_DIR distribution values of DATA_WIDTH bits each) and buffers it in a small FIFO. Each pixel is presented downstream with a valid/ready handshake, unpacked into the NUM_DIR lanes and tagged with its pixel address.
- Frames are DEPTH pixels long and are started explicitly.
- tlast framing is checked and a completion pulse is raised per frame.
- Sits between the DDR/DMA stream and the collision/streaming core.

Parameters:
DATA_WIDTH, 16, bits per direction value
NUM_DIR, 9, directions per pixel (D2Q9)
DEPTH, 2500, pixels per frame
ADDRESS_WIDTH, 12, pixel address width; must satisfy 2**ADDRESS_WIDTH >= DEPTH
FIFO_DEPTH, 4, buffer entries (power of two, >= 2)

Ports:
m00_axis_aclk  in  1  single clock
m00_axis_aresetn  in  1  reset; synchronous, active-high (asserted = 1), despite the port name
start  in  1  begin a frame; honoured only in IDLE
m00_axis_tvalid  in  1  upstream beat valid
m00_axis_tdata  in  NUM_DIR*DATA_WIDTH  packed pixel
m00_axis_tlast  in  1  upstream end-of-frame marker
m00_axis_tready  out  1  upstream ready
px_valid  out  1  pixel available downstream
px_ready  in  1  downstream accepts pixel
px_data  out  NUM_DIR*DATA_WIDTH  unpacked pixel; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
px_addr  out  ADDRESS_WIDTH  pixel index 0..DEPTH-1 within the frame
px_last  out  1  high with pixel DEPTH-1
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame completion
tlast_err  out  1  sticky framing error flag

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE and the FIFO is flushed.
  - Accept and emit counters are cleared to 0.
  - All outputs are 0: m00_axis_tready, px_valid, px_data, px_addr, px_last, busy, frame_done, tlast_err.
  - Reset mid-frame drops all buffered pixels; there is no partial output.
- Lane order, k = 0..8: N, NULL(rest), NE, E, SE, S, SW, W, NW.
  - The NUM_DIR*DATA_WIDTH bits are passed through bit-exact; there is no arithmetic.
- States:
  - IDLE: m00_axis_tready = 0. On start = 1, go to RUN, clear the counters and clear tlast_err.
  - RUN: accept beats until DEPTH beats are taken; emit pixels. Go to DONE on the cycle the pixel with px_last is handshaken (px_valid & px_ready).
  - DONE: frame_done = 1 for exactly this one cycle, then return to IDLE.
  - start outside IDLE is ignored.
- Upstream handshake:
  - m00_axis_tready = (state == RUN) & !fifo_full & (accept_cnt < DEPTH).
  - tready is combinational from registered state only; it must not depend on tvalid.
  - A beat is transferred when tvalid & tready. That cycle, tdata and the tag accept_cnt are written to the FIFO, and accept_cnt increments.
  - Once DEPTH beats are accepted, tready stays 0 until the next start. Excess upstream beats remain stalled.
- Downstream:
  - px_valid = !fifo_empty. px_data, px_addr and px_last come from the FIFO head.
  - The head pops on px_valid & px_ready.
  - px_data must remain stable while px_valid = 1 and px_ready = 0.
- Latency: a beat accepted in cycle N appears on px_* in cycle N+1 if the FIFO was empty. Full throughput is 1 pixel/cycle with px_ready held high.
- Simultaneous push and pop with the FIFO full is not allowed, because tready = 0 when full. With the FIFO empty, a push and a pop in the same cycle cannot occur.
- Framing check, per accepted beat with index i:
  - set tlast_err if tlast = 1 and i != DEPTH-1;
  - set tlast_err if tlast = 0 and i == DEPTH-1.
  - tlast_err is sticky; it clears only on reset or an accepted start.
  - The frame always ends after DEPTH beats, regardless of tlast.
- Counter widths: accept_cnt and emit tags use ADDRESS_WIDTH+1 bits internally so that DEPTH is representable. px_last = (tag == DEPTH-1).

Decomposition:
- Package lbm_pkg holds:
  - NUM_DIR;
  - lane index constants DIR_N = 0, DIR_NULL = 1, DIR_NE = 2, DIR_E = 3, DIR_SE = 4, DIR_S = 5, DIR_SW = 6, DIR_W = 7, DIR_NW = 8;
  - the state encoding IDLE/RUN/DONE.
- One sub-module, lbm_sync_fifo: a parametrised synchronous FIFO (width NUM_DIR*DATA_WIDTH + ADDRESS_WIDTH, depth FIFO_DEPTH) with full/empty outputs.

Test Plan:
- Reset, then start with tvalid = 1 and px_ready = 1, DEPTH = 8, tdata lane k = 16'h0100+k, tlast on beat 7:
  - 8 pixels appear with px_addr 0..7 and lane values matching bit-exact;
  - px_last only on addr 7;
  - frame_done pulses once, 1 cycle after the last handshake;
  - tlast_err = 0.
- Backpressure, with px_ready = 0 for 10 cycles:
  - m00_axis_tready drops after exactly FIFO_DEPTH beats;
  - px_data stays stable;
  - releasing px_ready drains all 8 pixels in order with no loss or duplication.
- Framing errors:
  - tlast on beat 3 → tlast_err = 1 from the cycle after beat 3, and the frame still completes 8 pixels;
  - next start clears the flag;
  - missing tlast on beat 7 → tlast_err = 1.
- Overrun: upstream presents a 9th beat → tready stays 0 after 8 accepts. The 9th beat is accepted as addr 0 only after frame_done and a new start.
- Mid-frame reset after 3 accepts (1 still buffered) → next cycle px_valid = 0, busy = 0, tready = 0, and no frame_done pulse.
- start pulsed during RUN → ignored: counters unaffected, single frame_done.

Source files
------------

// File: rtl/lbm_axis_pixel_unpacker_pkg.sv
// Shared definitions for the lattice-Boltzmann pixel unpacker.
//   NUM_DIR          : directions per pixel (D2Q9)
//   DIR_*            : lane index of each direction inside a packed pixel
//   state_e          : frame controller states
package lbm_pkg;

    localparam int unsigned NUM_DIR = 9;

    // Lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH] of a packed pixel.
    localparam int unsigned DIR_N    = 0;
    localparam int unsigned DIR_NULL = 1;
    localparam int unsigned DIR_NE   = 2;
    localparam int unsigned DIR_E    = 3;
    localparam int unsigned DIR_SE   = 4;
    localparam int unsigned DIR_S    = 5;
    localparam int unsigned DIR_SW   = 6;
    localparam int unsigned DIR_W    = 7;
    localparam int unsigned DIR_NW   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lbm_axis_pixel_unpacker_if.sv
// Stream bundle of the pixel unpacker: upstream AXI-Stream beats in, unpacked pixels out.
//   m00_axis_tvalid/tdata/tlast/tready : upstream packed-pixel stream
//   px_valid/px_ready/px_data/px_addr/px_last : downstream pixel stream
// Modports: slave = the unpacker's view, master = the surrounding environment.
interface lbm_axis_pixel_unpacker_if #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NUM_DIR       = lbm_pkg::NUM_DIR,
    parameter int unsigned ADDRESS_WIDTH = 12
);

    localparam int unsigned PIXEL_WIDTH = NUM_DIR * DATA_WIDTH;

    logic                     m00_axis_tvalid;
    logic [PIXEL_WIDTH-1:0]   m00_axis_tdata;
    logic                     m00_axis_tlast;
    logic                     m00_axis_tready;

    logic                     px_valid;
    logic                     px_ready;
    logic [PIXEL_WIDTH-1:0]   px_data;
    logic [ADDRESS_WIDTH-1:0] px_addr;
    logic                     px_last;

    modport slave (
        input  m00_axis_tvalid,
        input  m00_axis_tdata,
        input  m00_axis_tlast,
        output m00_axis_tready,
        output px_valid,
        input  px_ready,
        output px_data,
        output px_addr,
        output px_last
    );

    modport master (
        output m00_axis_tvalid,
        output m00_axis_tdata,
        output m00_axis_tlast,
        input  m00_axis_tready,
        input  px_valid,
        output px_ready,
        input  px_data,
        input  px_addr,
        input  px_last
    );

endinterface

// File: rtl/lbm_axis_pixel_unpacker_fifo.sv
// Synchronous FIFO with a first-word-fall-through head.
//   clk, rst        : clock, synchronous active-high reset (flushes contents)
//   push, push_data : write one entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head_data       : current head entry, valid while !empty
//   full, empty     : occupancy flags
module lbm_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    // Extra pointer bit distinguishes full from empty when the indices match.
    logic [PTR_WIDTH:0] wr_ptr_q, rd_ptr_q;
    logic               do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                       (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);

endmodule

// File: rtl/lbm_axis_pixel_unpacker.sv
// AXI-Stream slave that takes one packed D2Q9 pixel per beat, buffers it and presents it
// downstream unpacked into NUM_DIR lanes, tagged with its index within the frame.
//   m00_axis_aclk     : clock
//   m00_axis_aresetn  : synchronous reset, active-HIGH despite the name
//   start             : begin a frame (only honoured when idle)
//   axis              : upstream beats and downstream pixels (slave modport)
//   busy              : frame in progress
//   frame_done        : one-cycle pulse after the last pixel handshake
//   tlast_err         : sticky flag, tlast disagreed with the beat index
module lbm_axis_pixel_unpacker #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NUM_DIR       = lbm_pkg::NUM_DIR,
    parameter int unsigned DEPTH         = 2500,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                            m00_axis_aclk,
    input  logic                            m00_axis_aresetn,
    input  logic                            start,
    lbm_axis_pixel_unpacker_if.slave        axis,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            tlast_err
);

    import lbm_pkg::*;

    localparam int unsigned PIXEL_WIDTH = NUM_DIR * DATA_WIDTH;
    localparam int unsigned ENTRY_WIDTH = PIXEL_WIDTH + ADDRESS_WIDTH;
    // One extra bit so that a count of DEPTH is representable.
    localparam int unsigned CNT_WIDTH   = ADDRESS_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0]     FRAME_LEN = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]     LAST_IDX  = CNT_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    state_e                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     accept_cnt_q, accept_cnt_d;
    logic                     tlast_err_q, tlast_err_d;

    logic                     fifo_full, fifo_empty;
    logic                     push, pop;
    logic [ENTRY_WIDTH-1:0]   push_entry, head_entry;
    logic [PIXEL_WIDTH-1:0]   head_data;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic                     head_last;

    // Registered state only; never looks at tvalid.
    assign axis.m00_axis_tready = (state_q == RUN) && !fifo_full && (accept_cnt_q < FRAME_LEN);

    assign push       = axis.m00_axis_tvalid && axis.m00_axis_tready;
    assign pop        = !fifo_empty && axis.px_ready;
    assign push_entry = {axis.m00_axis_tdata, accept_cnt_q[ADDRESS_WIDTH-1:0]};

    assign {head_data, head_addr} = head_entry;
    assign head_last              = (head_addr == LAST_ADDR);

    lbm_sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (m00_axis_aclk),
        .rst       (m00_axis_aresetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head is masked while empty so the outputs read zero out of reset.
    assign axis.px_valid = !fifo_empty;
    assign axis.px_data  = fifo_empty ? '0 : head_data;
    assign axis.px_addr  = fifo_empty ? '0 : head_addr;
    assign axis.px_last  = !fifo_empty && head_last;

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_aresetn) begin
            state_q      <= IDLE;
            accept_cnt_q <= '0;
            tlast_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            accept_cnt_q <= accept_cnt_d;
            tlast_err_q  <= tlast_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        accept_cnt_d = accept_cnt_q;
        tlast_err_d  = tlast_err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    accept_cnt_d = '0;
                    tlast_err_d  = 1'b0;
                end
            end
            RUN: begin
                if (push) begin
                    accept_cnt_d = accept_cnt_q + 1'b1;
                    // tlast must be high on exactly the final beat of the frame.
                    if (axis.m00_axis_tlast != (accept_cnt_q == LAST_IDX)) begin
                        tlast_err_d = 1'b1;
                    end
                end
                if (pop && head_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign tlast_err  = tlast_err_q;

endmodule

// File: tb/tb_lbm_axis_pixel_unpacker.sv
module tb_lbm_axis_pixel_unpacker;

    import lbm_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned ND    = 9;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned FD    = 4;
    localparam int unsigned PW    = ND * DW;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct {
        logic [PW-1:0] data;
        bit            last;
    } beat_t;

    typedef struct {
        logic [PW-1:0] data;
        int            addr;
    } pix_t;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic frame_done;
    logic tlast_err;

    lbm_axis_pixel_unpacker_if #(
        .DATA_WIDTH    (DW),
        .NUM_DIR       (ND),
        .ADDRESS_WIDTH (AW)
    ) axis ();

    lbm_axis_pixel_unpacker #(
        .DATA_WIDTH    (DW),
        .NUM_DIR       (ND),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (AW),
        .FIFO_DEPTH    (FD)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst),
        .start            (start),
        .axis             (axis),
        .busy             (busy),
        .frame_done       (frame_done),
        .tlast_err        (tlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: beats waiting upstream, pixels expected downstream in order.
    beat_t src[$];
    pix_t  exp_q[$];
    int    mode;
    int    acc;
    bit    err_m;
    bit    pushed_last;
    int    done_seen;
    int    dut_push;
    int    checks;
    int    errors;

    task automatic check_val(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_frame(input int last_at, input bit fixed);
        for (int i = 0; i < int'(DEPTH); i++) begin
            beat_t b;
            for (int k = 0; k < int'(ND); k++) begin
                if (fixed) b.data[k*DW +: DW] = DW'(16'h0100 + k);
                else       b.data[k*DW +: DW] = DW'($urandom);
            end
            b.last = (i == last_at);
            src.push_back(b);
        end
    endtask

    // One clock: drive at negedge, check just after, then advance the model for the posedge.
    task automatic step(input bit st, input int vpct, input int rpct);
        bit tr_exp;
        bit push;
        bit pop;
        @(negedge clk);
        start = st;
        if (pushed_last) axis.m00_axis_tvalid = 1'b0;
        pushed_last = 1'b0;
        if (!axis.m00_axis_tvalid && src.size() > 0 && int'($urandom_range(0, 99)) < vpct) begin
            axis.m00_axis_tvalid = 1'b1;
            axis.m00_axis_tdata  = src[0].data;
            axis.m00_axis_tlast  = src[0].last;
        end
        axis.px_ready = (int'($urandom_range(0, 99)) < rpct);
        #1;
        tr_exp = (mode == M_RUN) && (exp_q.size() < int'(FD)) && (acc < int'(DEPTH));
        check_val("tready", axis.m00_axis_tready, tr_exp);
        check_val("px_valid", axis.px_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check_val("px_data", axis.px_data, exp_q[0].data);
            check_val("px_addr", axis.px_addr, exp_q[0].addr);
            check_val("px_last", axis.px_last, exp_q[0].addr == int'(DEPTH) - 1);
        end
        check_val("busy", busy, mode != M_IDLE);
        check_val("frame_done", frame_done, mode == M_DONE);
        check_val("tlast_err", tlast_err, err_m);
        if (frame_done) done_seen++;
        if (axis.m00_axis_tvalid && axis.m00_axis_tready) dut_push++;

        push = axis.m00_axis_tvalid && tr_exp;
        pop  = (exp_q.size() > 0) && axis.px_ready;
        if (mode == M_IDLE) begin
            if (st) begin
                mode  = M_RUN;
                acc   = 0;
                err_m = 1'b0;
            end
        end else if (mode == M_RUN) begin
            if (pop) begin
                if (exp_q[0].addr == int'(DEPTH) - 1) mode = M_DONE;
                void'(exp_q.pop_front());
            end
            if (push) begin
                exp_q.push_back('{data: src[0].data, addr: acc});
                if (src[0].last != (acc == int'(DEPTH) - 1)) err_m = 1'b1;
                acc++;
                void'(src.pop_front());
                pushed_last = 1'b1;
            end
        end else begin
            mode = M_IDLE;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst                  = 1'b1;
        start                = 1'b0;
        axis.m00_axis_tvalid = 1'b0;
        axis.px_ready        = 1'b0;
        pushed_last          = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_tready", axis.m00_axis_tready, 0);
        check_val("rst_px_valid", axis.px_valid, 0);
        check_val("rst_px_data", axis.px_data, 0);
        check_val("rst_px_addr", axis.px_addr, 0);
        check_val("rst_px_last", axis.px_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_tlast_err", tlast_err, 0);
        mode  = M_IDLE;
        acc   = 0;
        err_m = 1'b0;
        exp_q.delete();
    endtask

    // Start a frame and run it to completion; optional initial stall and mid-frame start pulse.
    task automatic run_frame(input int vpct, input int rpct, input int stall, input int mid_start);
        int n;
        done_seen = 0;
        step(1'b1, vpct, rpct);
        if (stall > 0) begin
            dut_push = 0;
            for (int i = 0; i < stall; i++) step(1'b0, 100, 0);
            check_val("stall_accepts", dut_push, FD);
        end
        n = 0;
        while (mode != M_IDLE && n < 400) begin
            step(n == mid_start, vpct, rpct);
            n++;
        end
        check_val("frame_end", mode, M_IDLE);
        check_val("done_cnt", done_seen, 1);
    endtask

    initial begin
        checks               = 0;
        errors               = 0;
        mode                 = M_IDLE;
        acc                  = 0;
        err_m                = 1'b0;
        pushed_last          = 1'b0;
        rst                  = 1'b1;
        start                = 1'b0;
        axis.m00_axis_tvalid = 1'b0;
        axis.m00_axis_tdata  = '0;
        axis.m00_axis_tlast  = 1'b0;
        axis.px_ready        = 1'b0;

        reset_dut();

        // Fixed lane pattern, full throughput.
        add_frame(DEPTH - 1, 1'b1);
        run_frame(100, 100, 0, -1);
        check_val("clean_err", tlast_err, 0);

        // Downstream stall for 10 cycles.
        add_frame(DEPTH - 1, 1'b0);
        run_frame(100, 100, 10, -1);

        // Early tlast, then a clean frame clears the flag, then missing tlast.
        add_frame(3, 1'b0);
        run_frame(100, 100, 0, -1);
        check_val("early_tlast_err", tlast_err, 1);
        add_frame(DEPTH - 1, 1'b0);
        run_frame(100, 100, 0, -1);
        check_val("err_cleared", tlast_err, 0);
        add_frame(-1, 1'b0);
        run_frame(100, 100, 0, -1);
        check_val("missing_tlast_err", tlast_err, 1);

        // Overrun: next frame's first beat waits until the new start, then lands at addr 0.
        add_frame(DEPTH - 1, 1'b0);
        add_frame(DEPTH - 1, 1'b0);
        run_frame(100, 100, 0, -1);
        check_val("overrun_held", axis.m00_axis_tvalid, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 100, 100);
        run_frame(100, 100, 0, -1);

        // start pulse in the middle of a frame.
        add_frame(DEPTH - 1, 1'b0);
        run_frame(100, 100, 0, 3);

        // Mid-frame reset with one pixel still buffered.
        add_frame(DEPTH - 1, 1'b0);
        step(1'b1, 100, 100);
        for (int i = 0; i < 3; i++) step(1'b0, 100, 100);
        check_val("pre_rst_acc", dut_push >= 3, 1);
        src.delete();
        reset_dut();
        done_seen = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 100, 100);
        check_val("rst_no_done", done_seen, 0);

        // Random handshaking and data.
        for (int f = 0; f < 5; f++) begin
            add_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : DEPTH - 1,
                      1'b0);
            run_frame(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
